// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, state, pc_sel and RF_sel encodings for the sequencer
// No ports; imported by isa_decode and instr_sequencer.
package cpu_pkg;
   localparam logic [3:0] OPC_LI  = 4'h8;
   localparam logic [3:0] OPC_LW  = 4'h9;
   localparam logic [3:0] OPC_SW  = 4'hA;
   localparam logic [3:0] OPC_BIZ = 4'hB;
   localparam logic [3:0] OPC_BNZ = 4'hC;
   localparam logic [3:0] OPC_JAL = 4'hD;
   localparam logic [3:0] OPC_JMP = 4'hE;
   localparam logic [3:0] OPC_JR  = 4'hF;

   localparam logic [1:0] PC_REL = 2'b00;
   localparam logic [1:0] PC_ABS = 2'b01;
   localparam logic [1:0] PC_REG = 2'b10;

   localparam logic [1:0] RF_ALU = 2'b00;
   localparam logic [1:0] RF_MEM = 2'b01;
   localparam logic [1:0] RF_IMM = 2'b10;

   localparam logic [3:0] LINK_REG = 4'hF;

   typedef enum logic [3:0] {
      OP_ALU, OP_LI, OP_LW, OP_SW, OP_BIZ, OP_BNZ, OP_JAL, OP_JMP, OP_JR
   } op_e;

   // SW, BIZ, BNZ and JR all begin by reading Ra with identical strobes, so
   // they share S_RA_RD; this keeps all eighteen logical steps in 4 bits.
   typedef enum logic [3:0] {
      S_INIT    = 4'd0,
      S_FETCH   = 4'd1,
      S_FETCH_W = 4'd2,
      S_DECODE  = 4'd3,
      S_ALU_RD  = 4'd4,
      S_ALU_WB  = 4'd5,
      S_LI_WB   = 4'd6,
      S_LW_RD   = 4'd7,
      S_LW_WB   = 4'd8,
      S_RA_RD   = 4'd9,
      S_SW_WR   = 4'd10,
      S_BR_WAIT = 4'd11,
      S_BR_EV   = 4'd12,
      S_JMP_EX  = 4'd13,
      S_JAL_EX  = 4'd14,
      S_JR_EX   = 4'd15
   } state_e;
endpackage

// File: rtl/isa_decode.sv
// isa_decode: combinational opcode class and field extraction from IR
// ir_i      : instruction word
// op_o      : opcode class
// alu_sel_o : ALU function IR[14:12]
// rd_o      : Rd/Ra IR[11:8]; rp_o IR[7:4]; rq_o IR[3:0]
// imm_o     : imm/addr/offset IR[7:0]
module isa_decode
   import cpu_pkg::*;
(
   input  logic [15:0] ir_i,
   output op_e         op_o,
   output logic [2:0]  alu_sel_o,
   output logic [3:0]  rd_o,
   output logic [3:0]  rp_o,
   output logic [3:0]  rq_o,
   output logic [7:0]  imm_o
);
   always_comb begin
      op_o = OP_ALU;
      if (ir_i[15])
         case (ir_i[15:12])
            OPC_LI:  op_o = OP_LI;
            OPC_LW:  op_o = OP_LW;
            OPC_SW:  op_o = OP_SW;
            OPC_BIZ: op_o = OP_BIZ;
            OPC_BNZ: op_o = OP_BNZ;
            OPC_JAL: op_o = OP_JAL;
            OPC_JMP: op_o = OP_JMP;
            default: op_o = OP_JR;
         endcase
   end

   assign alu_sel_o = ir_i[14:12];
   assign rd_o      = ir_i[11:8];
   assign rp_o      = ir_i[7:4];
   assign rq_o      = ir_i[3:0];
   assign imm_o     = ir_i[7:0];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM driving PC, memory and register file
// clk, rst_n          : clock, asynchronous active-low reset
// run                 : permits a new fetch
// IR_d, zero_flag     : instruction word and Rp==0 flag from datapath
// PC_addr             : current PC, used as JAL link value
// D_*                 : data memory address/select/strobes
// W_*, Rp_*, Rq_*     : register file write/read ports
// RF_W_data, RF_sel   : immediate write data and write source select
// ALU_sel             : ALU function
// IR_ld, PC_*, pc_sel : instruction register and PC control
// state_o             : current state encoding
module instr_sequencer
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [15:0] IR_d,
   input  logic        zero_flag,
   input  logic [7:0]  PC_addr,
   output logic [7:0]  D_addr,
   output logic [7:0]  RF_W_data,
   output logic [3:0]  W_addr,
   output logic [3:0]  Rp_addr,
   output logic [3:0]  Rq_addr,
   output logic [2:0]  ALU_sel,
   output logic [1:0]  RF_sel,
   output logic [1:0]  pc_sel,
   output logic [3:0]  state_o,
   output logic        D_rd,
   output logic        D_wr,
   output logic        W_wr,
   output logic        Rp_rd,
   output logic        Rq_rd,
   output logic        IR_ld,
   output logic        D_addr_sel,
   output logic        PC_inc,
   output logic        PC_clr,
   output logic        PC_ld
);
   state_e     state_q, state_d;
   op_e        op;
   logic [2:0] alu_sel;
   logic [3:0] rd, rp, rq;
   logic [7:0] imm;
   logic       take;

   isa_decode u_dec (
      .ir_i      (IR_d),
      .op_o      (op),
      .alu_sel_o (alu_sel),
      .rd_o      (rd),
      .rp_o      (rp),
      .rq_o      (rq),
      .imm_o     (imm)
   );

   assign take    = (op == OP_BIZ && zero_flag) || (op == OP_BNZ && !zero_flag);
   assign state_o = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:    state_d = S_FETCH;
         S_FETCH:   state_d = run ? S_FETCH_W : S_FETCH;
         S_FETCH_W: state_d = S_DECODE;
         S_DECODE:
            case (op)
               OP_ALU:  state_d = S_ALU_RD;
               OP_LI:   state_d = S_LI_WB;
               OP_LW:   state_d = S_LW_RD;
               OP_JAL:  state_d = S_JAL_EX;
               OP_JMP:  state_d = S_JMP_EX;
               default: state_d = S_RA_RD;
            endcase
         S_ALU_RD:  state_d = S_ALU_WB;
         S_LW_RD:   state_d = S_LW_WB;
         S_RA_RD:   state_d = op == OP_SW ? S_SW_WR : op == OP_JR ? S_JR_EX : S_BR_WAIT;
         S_BR_WAIT: state_d = S_BR_EV;
         default:   state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= S_INIT;
      else        state_q <= state_d;

   always_comb begin
      D_addr     = '0;
      RF_W_data  = '0;
      W_addr     = '0;
      Rp_addr    = '0;
      Rq_addr    = '0;
      ALU_sel    = '0;
      RF_sel     = RF_ALU;
      pc_sel     = PC_REL;
      D_rd       = 1'b0;
      D_wr       = 1'b0;
      W_wr       = 1'b0;
      Rp_rd      = 1'b0;
      Rq_rd      = 1'b0;
      IR_ld      = 1'b0;
      D_addr_sel = 1'b0;
      PC_inc     = 1'b0;
      PC_clr     = 1'b0;
      PC_ld      = 1'b0;
      case (state_q)
         S_INIT:    PC_clr = 1'b1;
         S_FETCH:   D_rd = run;
         S_FETCH_W: begin
            IR_ld  = 1'b1;
            PC_inc = 1'b1;
         end
         S_ALU_RD:  begin
            Rp_rd   = 1'b1;
            Rq_rd   = 1'b1;
            Rp_addr = rp;
            Rq_addr = rq;
         end
         S_ALU_WB:  begin
            W_wr    = 1'b1;
            W_addr  = rd;
            ALU_sel = alu_sel;
         end
         S_LI_WB:   begin
            W_wr      = 1'b1;
            W_addr    = rd;
            RF_sel    = RF_IMM;
            RF_W_data = imm;
         end
         S_LW_RD:   begin
            D_addr_sel = 1'b1;
            D_addr     = imm;
            D_rd       = 1'b1;
         end
         S_LW_WB:   begin
            W_wr   = 1'b1;
            W_addr = rd;
            RF_sel = RF_MEM;
         end
         S_RA_RD:   begin
            Rp_rd   = 1'b1;
            Rp_addr = rd;
         end
         S_SW_WR:   begin
            D_addr_sel = 1'b1;
            D_addr     = imm;
            D_wr       = 1'b1;
         end
         S_BR_EV:   PC_ld = take;
         S_JMP_EX:  begin
            PC_ld  = 1'b1;
            pc_sel = PC_ABS;
         end
         S_JAL_EX:  begin
            W_wr      = 1'b1;
            W_addr    = LINK_REG;
            RF_sel    = RF_IMM;
            RF_W_data = PC_addr;
            PC_ld     = 1'b1;
            pc_sel    = PC_ABS;
         end
         S_JR_EX:   begin
            PC_ld  = 1'b1;
            pc_sel = PC_REG;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer
module tb_instr_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, zero_flag = 1'b0;
   logic [15:0] IR_d = '0;
   logic [7:0]  PC_addr = 8'h11;
   logic [7:0]  D_addr, RF_W_data;
   logic [3:0]  W_addr, Rp_addr, Rq_addr, state_o;
   logic [2:0]  ALU_sel;
   logic [1:0]  RF_sel, pc_sel;
   logic        D_rd, D_wr, W_wr, Rp_rd, Rq_rd, IR_ld, D_addr_sel, PC_inc, PC_clr, PC_ld;
   int          n_tests = 0, n_fail = 0, cyc = 0, t0;

   instr_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run), .IR_d(IR_d), .zero_flag(zero_flag),
      .PC_addr(PC_addr), .D_addr(D_addr), .RF_W_data(RF_W_data), .W_addr(W_addr),
      .Rp_addr(Rp_addr), .Rq_addr(Rq_addr), .ALU_sel(ALU_sel), .RF_sel(RF_sel),
      .pc_sel(pc_sel), .state_o(state_o), .D_rd(D_rd), .D_wr(D_wr), .W_wr(W_wr),
      .Rp_rd(Rp_rd), .Rq_rd(Rq_rd), .IR_ld(IR_ld), .D_addr_sel(D_addr_sel),
      .PC_inc(PC_inc), .PC_clr(PC_clr), .PC_ld(PC_ld)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_fetch(input string tag, input int lat);
      int c = 0;
      do begin
         check({tag, "_excl"}, {PC_ld & PC_inc, D_rd & D_wr}, 0);
         step(1);
         c++;
      end while (state_o != 4'd1 && c < 20);
      check({tag, "_lat"}, cyc - t0, lat);
   endtask

   initial begin
      #1;
      check("rst_state", state_o, 0);
      check("rst_strobes", {PC_clr, D_rd, W_wr, IR_ld, PC_ld}, 5'b10000);
      check("rst_bus", {D_addr, W_addr, RF_W_data}, 0);
      #11 rst_n = 1'b1;
      #1 check("init_hold", state_o, 0);
      step(1);
      check("init_to_fetch", state_o, 1);
      for (int i = 0; i < 10; i++) begin
         check("halt", {state_o, D_rd, IR_ld}, {4'd1, 2'b00});
         step(1);
      end
      IR_d = 16'h835A;
      run  = 1'b1;
      #1 check("fetch_rd", {D_rd, D_addr_sel}, 2'b10);
      t0 = cyc;
      step(1);
      check("fetch_w", {state_o, IR_ld, PC_inc, PC_ld}, {4'd2, 3'b110});
      step(1);
      check("decode", {state_o, W_wr, D_rd, IR_ld, PC_ld, Rp_rd}, {4'd3, 5'b0});
      step(1);
      check("li_wb", {W_wr, W_addr, RF_sel, RF_W_data}, {1'b1, 4'h3, 2'b10, 8'h5A});
      wait_fetch("li", 4);

      IR_d = 16'h1123; t0 = cyc;
      step(3);
      check("alu_rd", {state_o, Rp_rd, Rq_rd, Rp_addr, Rq_addr}, {4'd4, 2'b11, 4'h2, 4'h3});
      step(1);
      check("alu_wb", {W_wr, W_addr, ALU_sel, RF_sel}, {1'b1, 4'h1, 3'b001, 2'b00});
      wait_fetch("alu", 5);

      IR_d = 16'hB204; zero_flag = 1'b1; t0 = cyc;
      step(3);
      check("br_rd", {Rp_rd, Rp_addr}, {1'b1, 4'h2});
      step(2);
      check("biz_take", {state_o, PC_ld, pc_sel, PC_inc}, {4'd12, 1'b1, 2'b00, 1'b0});
      wait_fetch("biz", 6);
      zero_flag = 1'b0; t0 = cyc;
      step(5);
      check("biz_not", {state_o, PC_ld}, {4'd12, 1'b0});
      wait_fetch("biz0", 6);
      IR_d = 16'hC204; t0 = cyc;
      step(5);
      check("bnz_take", {PC_ld, pc_sel}, {1'b1, 2'b00});
      wait_fetch("bnz", 6);
      zero_flag = 1'b1; t0 = cyc;
      step(5);
      check("bnz_not", PC_ld, 0);
      wait_fetch("bnz1", 6);

      IR_d = 16'hD040; t0 = cyc;
      step(3);
      check("jal", {W_addr, RF_W_data, W_wr, PC_ld, pc_sel, RF_sel}, {4'hF, 8'h11, 2'b11, 2'b01, 2'b10});
      wait_fetch("jal", 4);
      IR_d = 16'hE077; t0 = cyc;
      step(3);
      check("jmp", {PC_ld, pc_sel, W_wr}, {1'b1, 2'b01, 1'b0});
      wait_fetch("jmp", 4);
      IR_d = 16'hF300; t0 = cyc;
      step(3);
      check("jr_rd", {Rp_rd, Rp_addr}, {1'b1, 4'h3});
      step(1);
      check("jr_ex", {PC_ld, pc_sel}, {1'b1, 2'b10});
      wait_fetch("jr", 5);
      IR_d = 16'hA512; t0 = cyc;
      step(3);
      check("sw_rd", {Rp_rd, Rp_addr}, {1'b1, 4'h5});
      step(1);
      check("sw_wr", {D_wr, D_rd, D_addr_sel, D_addr}, {3'b101, 8'h12});
      wait_fetch("sw", 5);

      IR_d = 16'h9433; run = 1'b0; t0 = cyc;
      #1 check("halt_norun", D_rd, 0);
      run = 1'b1;
      step(3);
      check("lw_rd", {D_rd, D_addr_sel, D_addr}, {2'b11, 8'h33});
      run = 1'b0;
      step(1);
      check("lw_wb", {state_o, W_wr, W_addr, RF_sel}, {4'd8, 1'b1, 4'h4, 2'b01});
      rst_n = 1'b0;
      #1 check("rst_abort", {state_o, W_wr, PC_clr}, {4'd0, 2'b01});
      run = 1'b1;
      #2 rst_n = 1'b1;
      #1 check("rst_init", state_o, 0);
      step(1);
      check("rst_fetch", {state_o, D_rd, D_addr_sel}, {4'd1, 2'b10});

      IR_d = 16'h0567; t0 = cyc;
      step(1);
      run = 1'b0;
      wait_fetch("alu_norun", 5);
      step(2);
      check("halt_after", {state_o, D_rd}, {4'd1, 1'b0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports: run  in  1  high = sequencer may start a new fetch.
REQ-004 SHALL have ports: IR_d  in  16  instruction register contents.
REQ-005 SHALL have ports: zero_flag  in  1  registered Rp_data==0 flag from datapath.
REQ-006 SHALL have ports: PC_addr  in  8  current program counter value.
REQ-007 SHALL have outputs: D_addr 8, RF_W_data 8, W_addr 4, Rp_addr 4, Rq_addr 4, ALU_sel 3, RF_sel 2, pc_sel 2, state_o 4.
REQ-008 SHALL have 1-bit outputs: D_rd, D_wr, W_wr, Rp_rd, Rq_rd, IR_ld, D_addr_sel, PC_inc, PC_clr, PC_ld.

Function
REQ-009 SHALL decode opcode IR_d[15:12]: 0xxx ALU (ALU_sel=IR_d[14:12]), 8 LI, 9 LW, A SW, B BIZ, C BNZ, D JAL, E JMP, F JR.
REQ-010 SHALL use fields: Rd/Ra=IR_d[11:8], Rp=IR_d[7:4], Rq=IR_d[3:0], imm/addr/offset=IR_d[7:0].
REQ-011 SHALL drive outputs as Moore decode of state plus IR_d; every strobe is 0 unless listed for the state; unlisted buses hold 0.
REQ-012 INIT: PC_clr=1 -> FETCH.
REQ-013 FETCH: if run=1, D_addr_sel=0, D_rd=1 -> FETCH_W; if run=0, stay with all strobes 0.
REQ-014 FETCH_W: IR_ld=1, PC_inc=1 -> DECODE.
REQ-015 DECODE: no strobes; branch to first execute state of the opcode.
REQ-016 ALU: ALU_RD (Rp_rd=Rq_rd=1, Rp_addr, Rq_addr) -> ALU_WB (W_wr=1, RF_sel=00, W_addr=Rd, ALU_sel) -> FETCH.
REQ-017 LI: LI_WB (W_wr=1, RF_sel=10, W_addr=Rd, RF_W_data=imm) -> FETCH.
REQ-018 LW: LW_RD (D_addr_sel=1, D_addr=addr, D_rd=1) -> LW_WB (W_wr=1, RF_sel=01, W_addr=Rd) -> FETCH.
REQ-019 SW: SW_RD (Rp_rd=1, Rp_addr=Ra) -> SW_WR (D_addr_sel=1, D_addr=addr, D_wr=1) -> FETCH.
REQ-020 BIZ/BNZ: BR_RD (Rp_rd=1, Rp_addr=Ra) -> BR_WAIT (flag settles) -> BR_EV (PC_ld=1, pc_sel=00 relative iff BIZ&zero_flag or BNZ&~zero_flag) -> FETCH.
REQ-021 JMP: JMP_EX (PC_ld=1, pc_sel=01 absolute) -> FETCH.
REQ-022 JAL: JAL_EX (W_wr=1, W_addr=4'hF, RF_sel=10, RF_W_data=PC_addr, PC_ld=1, pc_sel=01) in the same cycle -> FETCH.
REQ-023 JR: JR_RD (Rp_rd=1, Rp_addr=Ra) -> JR_EX (PC_ld=1, pc_sel=10 register) -> FETCH.
REQ-024 pc_sel encoding: 00 PC+offset-1, 01 IR_d[7:0], 10 Rp_data[7:0]; 8-bit wrap, no overflow detection.
REQ-025 Latency fetch-to-fetch: LI/JMP/JAL 4, ALU/LW/SW/JR 5, branch 6 cycles.
REQ-026 run deasserted mid-instruction SHALL NOT stall; current instruction completes, halt occurs at next FETCH.
REQ-027 PC_ld and PC_inc SHALL never be asserted together; D_rd and D_wr never together.
REQ-028 state_o SHALL equal current state encoding for display.

Reset
REQ-029 rst_n low SHALL force state INIT immediately, aborting any instruction; outputs show INIT decode (PC_clr=1, all other strobes 0, buses 0).
REQ-030 After rst_n rises, INIT SHALL last exactly one clk, then FETCH.

Structure
REQ-031 Opcode constants, state encoding, pc_sel and RF_sel encodings SHALL live in shared package cpu_pkg.
REQ-032 Combinational field/opcode decode SHALL be sub-module isa_decode; state register and output decode stay in instr_sequencer.

Verification
REQ-033 Reset during LW_WB -> W_wr=0, PC_clr=1 at once; after release one INIT cycle then FETCH with D_rd=1, D_addr_sel=0.
REQ-034 IR_d=0x835A -> LI_WB: W_wr=1, W_addr=3, RF_sel=10, RF_W_data=0x5A; next FETCH 4 cycles after prior FETCH.
REQ-035 IR_d=0x1123 -> ALU_RD Rp_addr=2, Rq_addr=3; ALU_WB W_addr=1, ALU_sel=001.
REQ-036 IR_d=0xB204, zero_flag=1 -> BR_EV PC_ld=1, pc_sel=00; zero_flag=0 -> PC_ld=0; 0xC204 inverse.
REQ-037 IR_d=0xD040, PC_addr=0x11 -> JAL_EX W_addr=F, RF_W_data=0x11, W_wr=1, PC_ld=1, pc_sel=01.
REQ-038 run=0 at FETCH -> state holds, D_rd=0, IR_ld=0 for 10 cycles; run=1 -> FETCH_W next cycle.
